// File: rtl/stdout_tx_pkg.sv
// ---------------------------------------------------------------------------
// stdout_tx_pkg
//   Shared types and default configuration for the stdout serial drain.
//   - stdout_tx_state_t     : UART transmitter states
//   - stdout_unpack_state_t : buffer unpacker states
//   - STDOUT_TX_CLKS_PER_BIT / STDOUT_TX_FIFO_DEPTH : top-level defaults
// ---------------------------------------------------------------------------
package stdout_tx_pkg;

    localparam int unsigned STDOUT_TX_CLKS_PER_BIT = 16;
    localparam int unsigned STDOUT_TX_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } stdout_tx_state_t;

    typedef enum logic {
        U_IDLE,
        U_RUN
    } stdout_unpack_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   First-word-fall-through synchronous FIFO. rdata always shows the head
//   entry while empty==0. Synchronous active-low reset clears the pointers.
//   Ports:
//     clock, reset       : clock, synchronous active-low reset
//     push, wdata        : write request and data (ignored when full)
//     pop                : consume head entry (ignored when empty)
//     rdata              : head entry
//     full, empty, count : occupancy status
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full  = (count == (AW+1)'(DEPTH));
        empty = (count == '0);
        wr_en = push && !full;
        rd_en = pop && !empty;
        rdata = mem[rptr];
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stdout_tx.sv
// ---------------------------------------------------------------------------
// stdout_tx
//   Serial drain for the simulation stdout sink. Each stdout_taken pulse
//   delivers a 64-bit buffer (first char in [63:55+1], terminated by 0x00 or
//   after 8 bytes). Buffers are unpacked one byte per cycle into a character
//   FIFO and sent out as 8N1 UART frames, LSB first.
//   Ports:
//     clock, reset         : clock, synchronous active-low reset
//     stdout_taken, buffer : buffer hand-off pulse and its data
//     tx                   : UART line, idle high
//     busy                 : unpacking, pending, FIFO non-empty or frame out
//     overflow             : sticky, a buffer was dropped
//     fifo_count           : character FIFO occupancy
//   Build option:
//     STDOUT_TX_SIM_PRINT_EN : echo each popped character with $write
// ---------------------------------------------------------------------------
module stdout_tx
    import stdout_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = STDOUT_TX_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = STDOUT_TX_FIFO_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stdout_taken,
    input  logic [63:0]                  buffer,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    // Unpacker
    stdout_unpack_state_t u_state;
    logic [63:0]          shadow;
    logic [2:0]           idx;
    logic [63:0]          pend;
    logic                 pend_valid;
    logic [7:0]           cur_byte;
    logic                 char_push;
    logic                 u_finish;

    // Transmitter
    stdout_tx_state_t     t_state;
    logic [CW-1:0]        baud;
    logic [2:0]           bit_idx;
    logic [7:0]           data;
    logic                 char_pop;

    // FIFO
    logic [7:0]           fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_comb begin
        // {~idx,3'b000} == 8*(7-idx): byte idx counted from the MSB end
        cur_byte  = shadow[{~idx, 3'b000} +: 8];
        char_push = (u_state == U_RUN) && (cur_byte != '0) && !fifo_full;
        u_finish  = (u_state == U_RUN) &&
                    ((cur_byte == '0) || (char_push && (idx == 3'd7)));
        char_pop  = (t_state == T_IDLE) && !fifo_empty;
        busy      = (u_state == U_RUN) || pend_valid || !fifo_empty ||
                    (t_state != T_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            u_state    <= U_IDLE;
            shadow     <= '0;
            idx        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (u_state)
                U_IDLE: begin
                    if (stdout_taken) begin
                        shadow  <= buffer;
                        idx     <= '0;
                        u_state <= U_RUN;
                    end
                end
                U_RUN: begin
                    if (u_finish) begin
                        idx <= '0;
                        if (pend_valid) begin
                            // pending advances; a simultaneous pulse refills it
                            shadow     <= pend;
                            pend_valid <= stdout_taken;
                            if (stdout_taken) pend <= buffer;
                        end else if (stdout_taken) begin
                            shadow <= buffer;
                        end else begin
                            u_state <= U_IDLE;
                        end
                    end else begin
                        if (char_push) idx <= idx + 3'd1;
                        if (stdout_taken) begin
                            if (!pend_valid) begin
                                pend       <= buffer;
                                pend_valid <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end
                default: u_state <= U_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (char_push),
        .wdata (cur_byte),
        .pop   (char_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            t_state <= T_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            data    <= '0;
            tx      <= 1'b1;
        end else begin
            case (t_state)
                T_IDLE: begin
                    if (!fifo_empty) begin
                        data    <= fifo_rdata;
                        baud    <= BAUD_MAX;
                        tx      <= 1'b0;
                        t_state <= T_START;
`ifdef STDOUT_TX_SIM_PRINT_EN
                        $write("%c", fifo_rdata);
`endif
                    end
                end
                T_START: begin
                    if (baud == '0) begin
                        baud    <= BAUD_MAX;
                        tx      <= data[0];
                        data    <= {1'b0, data[7:1]};
                        bit_idx <= '0;
                        t_state <= T_DATA;
                    end else begin
                        baud <= baud - CW'(1);
                    end
                end
                T_DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_MAX;
                        if (bit_idx == 3'd7) begin
                            tx      <= 1'b1;
                            t_state <= T_STOP;
                        end else begin
                            tx      <= data[0];
                            data    <= {1'b0, data[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud - CW'(1);
                    end
                end
                T_STOP: begin
                    if (baud == '0) t_state <= T_IDLE;
                    else            baud    <= baud - CW'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_tx.sv
// ---------------------------------------------------------------------------
// tb_stdout_tx
//   Two instances (FIFO depth 16 and 4, 4 clocks per bit) share stimulus.
//   A queue-based model predicts tx/busy/overflow/fifo_count every cycle;
//   a line decoder rebuilds transmitted bytes for table and sequence checks.
// ---------------------------------------------------------------------------
module tb_stdout_tx;
    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        taken = 1'b0;
    logic [63:0] buffer = '0;

    logic        tx0, busy0, ovf0;
    logic [4:0]  cnt0;
    logic        tx1, busy1, ovf1;
    logic [2:0]  cnt1;

    always #5 clock = ~clock;

    stdout_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut16 (
        .clock(clock), .reset(reset), .stdout_taken(taken), .buffer(buffer),
        .tx(tx0), .busy(busy0), .overflow(ovf0), .fifo_count(cnt0));

    stdout_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut4 (
        .clock(clock), .reset(reset), .stdout_taken(taken), .buffer(buffer),
        .tx(tx1), .busy(busy1), .overflow(ovf1), .fifo_count(cnt1));

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (per instance) ----------------
    logic [63:0] m_work [2][$];   // [0] = buffer being unpacked, [1] = pending
    int          m_pos  [2];
    logic [7:0]  m_fifo [2][$];
    int          m_txw  [2];      // cycles left in current frame
    logic [9:0]  m_frame[2];
    bit          m_ovf  [2];
    logic [7:0]  m_out  [2][$];   // every character sent, in order
    bit          m_ok = 0;

    task automatic model_step(input int d, input int depth);
        logic [7:0]  b;
        logic [63:0] cur;
        bit          pre_full;
        bit          fin;
        if (!reset) begin
            m_work[d].delete(); m_fifo[d].delete();
            m_pos[d] = 0; m_txw[d] = 0; m_ovf[d] = 0;
            return;
        end
        pre_full = (m_fifo[d].size() == depth);
        if (m_txw[d] > 0) m_txw[d]--;
        else if (m_fifo[d].size() > 0) begin
            b = m_fifo[d].pop_front();
            m_out[d].push_back(b);
            m_frame[d] = {1'b1, b, 1'b0};
            m_txw[d] = 10 * CPB;
        end
        fin = 0;
        if (m_work[d].size() > 0) begin
            cur = m_work[d][0];
            b = cur[63 - 8*m_pos[d] -: 8];
            if (b == 8'h00) fin = 1;
            else if (!pre_full) begin
                m_fifo[d].push_back(b);
                if (m_pos[d] == 7) fin = 1;
                else m_pos[d]++;
            end
        end
        if (fin) begin
            void'(m_work[d].pop_front());
            m_pos[d] = 0;
        end
        if (taken) begin
            if (m_work[d].size() < 2) m_work[d].push_back(buffer);
            else m_ovf[d] = 1;
        end
    endtask

    // ---------------- line decoder ----------------
    bit         rx_act[2];
    int         rx_t  [2];
    logic [7:0] rx_d  [2];
    logic [7:0] rx_q  [2][$];
    int         peak  [2];

    task automatic check_dut(input int d, input logic tx, input logic busy,
                             input logic ovf, input int cnt);
        string s;
        int    exp_tx;
        int    k;
        s = (d == 0) ? "d16" : "d4";
        exp_tx = (m_txw[d] == 0) ? 1 : int'(m_frame[d][(10*CPB - m_txw[d]) / CPB]);
        chk({s, "_tx"}, int'(tx), exp_tx);
        chk({s, "_busy"}, int'(busy),
            int'(m_work[d].size() > 0 || m_fifo[d].size() > 0 || m_txw[d] > 0));
        chk({s, "_overflow"}, int'(ovf), int'(m_ovf[d]));
        chk({s, "_fifo_count"}, cnt, m_fifo[d].size());
        if (cnt > peak[d]) peak[d] = cnt;
        if (!reset) rx_act[d] = 0;
        else if (!rx_act[d]) begin
            if (tx == 1'b0) begin rx_act[d] = 1; rx_t[d] = 0; end
        end else begin
            rx_t[d]++;
            if (rx_t[d] % CPB == CPB/2) begin
                k = rx_t[d] / CPB;
                if (k >= 1 && k <= 8) rx_d[d][k-1] = tx;
                else if (k == 9) begin
                    chk({s, "_stop_bit"}, int'(tx), 1);
                    rx_q[d].push_back(rx_d[d]);
                    rx_act[d] = 0;
                end
            end
        end
        if (rx_act[d] && rx_t[d] == CPB/2) chk({s, "_start_bit"}, int'(tx), 0);
    endtask

    always @(posedge clock) begin
        model_step(0, 16);
        model_step(1, 4);
        if (!reset) m_ok = 1;
        #1;
        if (m_ok) begin
            check_dut(0, tx0, busy0, ovf0, int'(cnt0));
            check_dut(1, tx1, busy1, ovf1, int'(cnt1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [63:0] b);
        @(negedge clock); buffer = b; taken = 1'b1;
        @(negedge clock); taken = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((busy0 || busy1 || rx_act[0] || rx_act[1]) && c < 5000) begin
            @(negedge clock); c++;
        end
        chk({name, "_drained"}, int'(busy0 || busy1), 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic clear_rx();
        rx_q[0].delete(); rx_q[1].delete();
        peak[0] = 0; peak[1] = 0;
    endtask

    task automatic chk_rx(input int d, input string name, input logic [63:0] w,
                          input int n, input int off);
        int act;
        for (int i = 0; i < n; i++) begin
            act = (off + i < rx_q[d].size()) ? int'(rx_q[d][off+i]) : -1;
            chk(name, act, int'(w[63 - 8*i -: 8]));
        end
    endtask

    function automatic logic [63:0] rand_buf();
        logic [63:0] b;
        int term;
        term = $urandom_range(0, 8);
        for (int j = 0; j < 8; j++) begin
            if (j < term)       b[63 - 8*j -: 8] = 8'($urandom_range(1, 255));
            else if (j == term) b[63 - 8*j -: 8] = 8'h00;
            else                b[63 - 8*j -: 8] = 8'($urandom);
        end
        return b;
    endfunction

    typedef struct {
        logic [63:0] bvec;
        int          n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] hseq;

        vecs[0] = '{64'h4869_00AA_BBCC_DDEE, 2, 64'h4869_0000_0000_0000};
        vecs[1] = '{64'h4142_4344_4546_4748, 8, 64'h4142_4344_4546_4748};
        vecs[2] = '{64'h0041_4243_4445_4647, 0, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h5A00_7777_7777_7777, 1, 64'h5A00_0000_0000_0000};
        vecs[4] = '{64'h3132_3334_3500_FFFF, 5, 64'h3132_3334_3500_0000};
        vecs[5] = '{64'h0A0D_FF80_0100_1234, 5, 64'h0A0D_FF80_0100_0000};

        // reset state
        repeat (2) @(negedge clock);
        chk("reset_tx", int'(tx0), 1);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_overflow", int'(ovf0), 0);
        chk("reset_fifo_count", int'(cnt0), 0);
        chk("reset_fifo_count_d4", int'(cnt1), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 'H' then 'i': exact line timing
        clear_rx();
        hseq = 10'b1010010000;
        @(negedge clock); buffer = 64'h4869_0000_0000_0000; taken = 1'b1;
        @(posedge clock);                       // edge N
        @(negedge clock); taken = 1'b0;
        @(posedge clock); #1;                   // N+1
        chk("hi_tx_n1", int'(tx0), 1);
        chk("hi_count_n1", int'(cnt0), 1);
        for (int k = 0; k < 10*CPB; k++) begin
            @(posedge clock); #1;               // N+2+k
            chk("hi_line_H", int'(tx0), int'(hseq[k / CPB]));
            if (k == 0) chk("hi_count_n2", int'(cnt0), 1);
        end
        @(posedge clock); #1;
        chk("hi_gap_idle", int'(tx0), 1);
        @(posedge clock); #1;
        chk("hi_i_start", int'(tx0), 0);
        wait_idle("hi");
        chk("hi_rx_count", rx_q[0].size(), 2);
        chk_rx(0, "hi_rx", 64'h4869_0000_0000_0000, 2, 0);

        // table-driven single buffers
        for (int v = 0; v < 6; v++) begin
            clear_rx();
            pulse(vecs[v].bvec);
            wait_idle("vec");
            chk("vec_rx_count", rx_q[0].size(), vecs[v].n);
            chk_rx(0, "vec_rx_byte", vecs[v].exp, vecs[v].n, 0);
        end

        // full 8-byte buffer: FIFO peak
        clear_rx();
        pulse(64'h4142_4344_4546_4748);
        wait_idle("abc");
        chk("abc_peak", peak[0], 7);
        chk("abc_rx_count", rx_q[0].size(), 8);

        // three consecutive pulses: third dropped
        clear_rx();
        @(negedge clock); buffer = 64'h4142_4344_4546_4748; taken = 1'b1;
        @(negedge clock); buffer = 64'h3132_3300_0000_0000;
        @(negedge clock); buffer = 64'h7878_7878_7878_7878;
        @(negedge clock); taken = 1'b0;
        wait_idle("ovf");
        chk("ovf_flag", int'(ovf0), 1);
        chk("ovf_flag_d4", int'(ovf1), 1);
        chk("ovf_rx_count", rx_q[0].size(), 11);
        chk_rx(0, "ovf_rx_first", 64'h4142_4344_4546_4748, 8, 0);
        chk_rx(0, "ovf_rx_second", 64'h3132_3300_0000_0000, 3, 8);
        do_reset();
        @(negedge clock);
        chk("ovf_cleared", int'(ovf0), 0);

        // depth-4 stall: two full buffers
        clear_rx();
        @(negedge clock); buffer = 64'h4142_4344_4546_4748; taken = 1'b1;
        @(negedge clock); buffer = 64'h494A_4B4C_4D4E_4F50;
        @(negedge clock); taken = 1'b0;
        wait_idle("stall");
        chk("stall_rx_count_d4", rx_q[1].size(), 16);
        chk_rx(1, "stall_rx_d4", 64'h4142_4344_4546_4748, 8, 0);
        chk_rx(1, "stall_rx_d4", 64'h494A_4B4C_4D4E_4F50, 8, 8);
        chk("stall_peak_d4", peak[1], 4);
        chk("stall_overflow_d4", int'(ovf1), 0);
        chk("stall_rx_count_d16", rx_q[0].size(), 16);

        // reset during a data bit
        clear_rx();
        pulse(64'h4869_0000_0000_0000);
        repeat (14) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        chk("midrst_tx", int'(tx0), 1);
        chk("midrst_count", int'(cnt0), 0);
        chk("midrst_busy", int'(busy0), 0);
        @(negedge clock); reset = 1'b1;
        clear_rx();
        pulse(64'h5A00_0000_0000_0000);
        wait_idle("midrst");
        chk("midrst_rx_count", rx_q[0].size(), 1);
        chk_rx(0, "midrst_rx_Z", 64'h5A00_0000_0000_0000, 1, 0);

        // random traffic: sparse then dense (drops and FIFO-full stalls)
        do_reset();
        clear_rx();
        m_out[0].delete(); m_out[1].delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            buffer = rand_buf();
            taken = (c < 2000) ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 5) == 0);
        end
        @(negedge clock); taken = 1'b0;
        wait_idle("rand");
        for (int d = 0; d < 2; d++) begin
            chk("rand_rx_count", rx_q[d].size(), m_out[d].size());
            for (int i = 0; i < m_out[d].size() && i < rx_q[d].size(); i++)
                chk("rand_rx_byte", int'(rx_q[d][i]), int'(m_out[d][i]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
